// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/stop/lap/clear sequencing, 1/100 s tick prescaler,
// sticky overflow flag and frozen lap snapshot driving the display mux.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000000,
    parameter int NDIG     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              clear,
    input  logic [4*NDIG-1:0] cnt_q,
    input  logic              chain_ovf,
    output logic              cnt_enb,
    output logic              cnt_clr,
    output logic [4*NDIG-1:0] disp_q,
    output logic              running,
    output logic              lap_active,
    output logic              ovf_flag
);

    localparam int            PW  = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STOP,
        LAP_RUN,
        LAP_STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     presc;
    logic [PW-1:0]     presc_nxt;
    logic [4*NDIG-1:0] snap;
    logic              snap_cap;
    logic              run_cur;
    logic              run_nxt;
    logic              lap_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority clear > start_stop > lap; a losing pulse is simply dropped.
    always_comb begin
        state_nxt = state;
        snap_cap  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:     state_nxt = RUN;
                RUN:      state_nxt = STOP;
                STOP:     state_nxt = RUN;
                LAP_RUN:  state_nxt = LAP_STOP;
                LAP_STOP: state_nxt = LAP_RUN;
                default:  state_nxt = IDLE;
            endcase
        end else if (lap) begin
            case (state)
                RUN: begin
                    state_nxt = LAP_RUN;
                    snap_cap  = 1'b1;
                end
                STOP: begin
                    state_nxt = LAP_STOP;
                    snap_cap  = 1'b1;
                end
                LAP_RUN:  state_nxt = RUN;
                LAP_STOP: state_nxt = STOP;
                default:  state_nxt = state;
            endcase
        end

        run_cur = (state == RUN) || (state == LAP_RUN);
        run_nxt = (state_nxt == RUN) || (state_nxt == LAP_RUN);
        lap_nxt = (state_nxt == LAP_RUN) || (state_nxt == LAP_STOP);

        // Held while not running so a resume finishes the partial tick.
        presc_nxt = presc;
        if (clear) begin
            presc_nxt = '0;
        end else if (run_cur) begin
            presc_nxt = (presc == TOP) ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc      <= '0;
            snap       <= '0;
            cnt_enb    <= 1'b0;
            cnt_clr    <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            cnt_clr    <= clear;
            cnt_enb    <= run_nxt && (presc_nxt == TOP);
            running    <= run_nxt;
            lap_active <= lap_nxt;
            if (snap_cap) begin
                snap <= cnt_q;
            end
            if (clear) begin
                ovf_flag <= 1'b0;
            end else if (run_cur && chain_ovf) begin
                ovf_flag <= 1'b1;
            end
        end
    end

    assign disp_q = lap_active ? snap : cnt_q;

endmodule
